// File: rtl/loader_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : loader_byte_fifo
// Purpose  : Merges the SD loader byte stream and the UART demux ROM port
//            into a single paced byte stream for GameLoader. The block locks
//            to whichever source delivers the first byte, buffers bytes in a
//            small circular FIFO, and emits them as one-cycle strobes. Strobes
//            are separated by a guaranteed minimum gap and are held off while
//            stall is high.
// Ports    : clk, resetn (async, active low), flush (sync clear)
//            sd_data/sd_valid                   - SD loader byte + strobe
//            uart_data/uart_addr/uart_write     - UART demux write port
//            stall                              - downstream busy
//            out_data/out_clk                   - GameLoader indata/indata_clk
//            src_lock                           - 00 none, 01 SD, 10 UART
//            level, overflow, drop_count, fwd_count - status
// Revision : 1.0 - initial release
// ============================================================================
module loader_byte_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          GAP       = 4,
  parameter logic [7:0]  UART_ADDR = 8'h37
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic [7:0]               sd_data,
  input  logic                     sd_valid,
  input  logic [7:0]               uart_data,
  input  logic [7:0]               uart_addr,
  input  logic                     uart_write,
  input  logic                     stall,
  output logic [7:0]               out_data,
  output logic                     out_clk,
  output logic [1:0]               src_lock,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic [21:0]              fwd_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [GW-1:0] c_GAP_LOAD = GW'(GAP - 1);
  localparam logic [GW-1:0] c_GAP_ONE  = GW'(1);
  localparam logic [AW:0]   c_PTR_ONE  = (AW+1)'(1);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_GAP  = 1'b1;

  localparam logic [1:0] c_LOCK_NONE = 2'b00;
  localparam logic [1:0] c_LOCK_SD   = 2'b01;
  localparam logic [1:0] c_LOCK_UART = 2'b10;

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [0:0]    r_state, w_state_nx;
  logic [GW-1:0] r_gap_cnt, w_gap_nx;
  logic [7:0]    r_out_data;
  logic          r_out_clk;
  logic [1:0]    r_lock, w_lock_nx;
  logic          r_ovf;
  logic [7:0]    r_drop;
  logic [21:0]   r_fwd;

  logic          w_empty, w_full, w_uart_q;
  logic          w_acc, w_drop_src, w_pop, w_push, w_ovf_drop;
  logic [7:0]    w_acc_data;
  logic [1:0]    w_drop_inc;
  logic [8:0]    w_drop_sum;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_uart_q = uart_write && (uart_addr == UART_ADDR);

  // Source arbitration: SD wins a simultaneous first byte; once locked,
  // only the locked source is accepted and the other source is dropped.
  always_comb begin
    w_acc      = 1'b0;
    w_acc_data = sd_data;
    w_lock_nx  = r_lock;
    w_drop_src = 1'b0;
    case (r_lock)
      c_LOCK_NONE: begin
        if (sd_valid) begin
          w_acc      = 1'b1;
          w_lock_nx  = c_LOCK_SD;
          w_drop_src = w_uart_q;
        end else if (w_uart_q) begin
          w_acc      = 1'b1;
          w_acc_data = uart_data;
          w_lock_nx  = c_LOCK_UART;
        end
      end
      c_LOCK_SD: begin
        w_acc      = sd_valid;
        w_drop_src = w_uart_q;
      end
      c_LOCK_UART: begin
        w_acc      = w_uart_q;
        w_acc_data = uart_data;
        w_drop_src = sd_valid;
      end
      default: begin
        w_acc = 1'b0;
      end
    endcase
  end

  // FSM output: pop decision, only taken while idle.
  always_comb begin
    w_pop = (r_state == c_ST_IDLE) && !w_empty && !stall;
  end

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push     = w_acc && (!w_full || w_pop);
  assign w_ovf_drop = w_acc && !w_push;
  assign w_drop_inc = {1'b0, w_drop_src} + {1'b0, w_ovf_drop};
  assign w_drop_sum = {1'b0, r_drop} + {7'b0, w_drop_inc};

  // FSM next state. The GAP state always lasts at least one cycle, so
  // GAP==1 still spaces strobes two cycles apart.
  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = r_gap_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (w_pop) begin
          w_state_nx = c_ST_GAP;
          w_gap_nx   = c_GAP_LOAD;
        end
      end
      c_ST_GAP: begin
        if (r_gap_cnt <= c_GAP_ONE) begin
          w_state_nx = c_ST_IDLE;
        end else begin
          w_gap_nx = r_gap_cnt - c_GAP_ONE;
        end
      end
      default: begin
        w_state_nx = c_ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= c_ST_IDLE;
      r_gap_cnt <= '0;
    end else if (flush) begin
      r_state   <= c_ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_gap_cnt <= w_gap_nx;
    end
  end

  // Storage array carries no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (!flush && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_acc_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out_data <= '0;
      r_out_clk  <= 1'b0;
      r_lock     <= c_LOCK_NONE;
      r_ovf      <= 1'b0;
      r_drop     <= '0;
      r_fwd      <= '0;
    end else if (flush) begin
      // out_data deliberately keeps its last value across a flush.
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_out_clk <= 1'b0;
      r_lock    <= c_LOCK_NONE;
      r_ovf     <= 1'b0;
      r_drop    <= '0;
      r_fwd     <= '0;
    end else begin
      r_lock    <= w_lock_nx;
      r_out_clk <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_out_data <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
        r_fwd      <= r_fwd + 22'd1;
      end
      if (w_ovf_drop) begin
        r_ovf <= 1'b1;
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign out_data   = r_out_data;
  assign out_clk    = r_out_clk;
  assign src_lock   = r_lock;
  assign level      = r_wr_ptr - r_rd_ptr;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
  assign fwd_count  = r_fwd;

endmodule
`default_nettype wire
